// File: rtl/idma_req_responder.sv
// Stand-in iDMA backend: queues requests, counts down ceil(length/BytesPerCycle) run cycles each,
// and returns in-order responses. Optional macro IDMA_REQ_RESPONDER_ERR_INJECT_EN adds err_inject_i.
module idma_req_responder #(
    parameter int unsigned LenWidth       = 32,
    parameter int unsigned BytesPerCycle  = 8,
    parameter int unsigned NumOutstanding = 4,
    parameter type idma_req_t = struct packed { logic [LenWidth-1:0] length; },
    parameter type idma_rsp_t = struct packed { logic error; }
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  idma_req_t idma_req_i,
    input  logic      idma_req_valid_i,
    output logic      idma_req_ready_o,
    output idma_rsp_t idma_rsp_o,
    output logic      idma_rsp_valid_o,
    input  logic      idma_rsp_ready_i,
    output logic      idma_busy_o
`ifdef IDMA_REQ_RESPONDER_ERR_INJECT_EN
    ,
    input  logic      err_inject_i
`endif
);

    localparam int unsigned PtrW  = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int unsigned CntW  = $clog2(NumOutstanding + 1);
    localparam int unsigned Shift = $clog2(BytesPerCycle);
    localparam int unsigned BeatW = LenWidth + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP
    } state_e;

    logic [BeatW-1:0] r_beats [NumOutstanding];
    logic             r_tag   [NumOutstanding];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;
    state_e           r_state;
    state_e           w_state_next;
    logic [BeatW-1:0] r_cnt;
    logic [BeatW-1:0] w_cnt_next;
    logic [BeatW-1:0] w_len_ext;
    logic [BeatW-1:0] w_beats_in;
    logic [PtrW-1:0]  w_rptr_inc;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_tag_in;
    idma_rsp_t        w_rsp;

    function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NumOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef IDMA_REQ_RESPONDER_ERR_INJECT_EN
    assign w_tag_in = err_inject_i;
`else
    assign w_tag_in = 1'b0;
`endif

    // One extra bit keeps the rounding add from wrapping at the maximum length.
    assign w_len_ext  = BeatW'(idma_req_i.length);
    assign w_beats_in = (w_len_ext == '0) ? BeatW'(1)
                      : ((w_len_ext + BeatW'(BytesPerCycle - 1)) >> Shift);

    assign w_full           = (r_count == CntW'(NumOutstanding));
    assign w_empty          = (r_count == '0);
    assign w_push           = idma_req_valid_i && !w_full;
    assign w_rptr_inc       = ptrInc(r_rptr);
    assign idma_req_ready_o = !w_full;
    assign idma_busy_o      = !w_empty || (r_state != S_IDLE);
    assign idma_rsp_o       = w_rsp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumOutstanding); i++) begin
                r_beats[i] <= '0;
                r_tag[i]   <= 1'b0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_beats[r_wptr] <= w_beats_in;
                r_tag[r_wptr]   <= w_tag_in;
                r_wptr          <= ptrInc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= w_rptr_inc;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A request arriving while the queue is otherwise drained loads straight from the input,
    // so neither an idle start nor a back-to-back hand-over loses a cycle.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_pop            = 1'b0;
        idma_rsp_valid_o = 1'b0;
        w_rsp            = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_cnt_next   = r_beats[r_rptr];
                    w_state_next = S_RUN;
                end else if (w_push) begin
                    w_cnt_next   = w_beats_in;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt <= BeatW'(1)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_RESP: begin
                idma_rsp_valid_o = 1'b1;
                w_rsp.error      = r_tag[r_rptr];
                if (idma_rsp_ready_i) begin
                    w_pop = 1'b1;
                    if (r_count > CntW'(1)) begin
                        w_cnt_next   = r_beats[w_rptr_inc];
                        w_state_next = S_RUN;
                    end else if (w_push) begin
                        w_cnt_next   = w_beats_in;
                        w_state_next = S_RUN;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_idma_req_responder.sv
// Bench for idma_req_responder: directed scenarios plus random traffic against a
// timestamp-based reference model of when each response must appear.
module tb_idma_req_responder;

    localparam int NOut = 4;
    localparam int Bpc  = 8;

    typedef struct packed { logic [31:0] length; } reqT;
    typedef struct packed { logic [6:0] id; logic error; } rspT;

    typedef struct {
        longint acc;
        longint beats;
        bit     err;
    } entryT;

    logic clk = 1'b0;
    logic rst_n;
    reqT  reqData;
    logic reqValid;
    logic reqReady;
    rspT  rspData;
    logic rspValid;
    logic rspReady;
    logic busy;
    logic errInject;

    entryT  mq[$];
    bit     popErr[$];
    longint cyc;
    longint hPrev;
    int     errors = 0;
    int     checks = 0;
    bit     obsValid, obsBusy, obsReady, lastAccepted, lastPopped;

    always #5 clk = ~clk;

    idma_req_responder #(
        .LenWidth      (32),
        .BytesPerCycle (Bpc),
        .NumOutstanding(NOut),
        .idma_req_t    (reqT),
        .idma_rsp_t    (rspT)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .idma_req_i      (reqData),
        .idma_req_valid_i(reqValid),
        .idma_req_ready_o(reqReady),
        .idma_rsp_o      (rspData),
        .idma_rsp_valid_o(rspValid),
        .idma_rsp_ready_i(rspReady),
        .idma_busy_o     (busy)
`ifdef IDMA_REQ_RESPONDER_ERR_INJECT_EN
        ,
        .err_inject_i    (errInject)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint modelBeats(input longint len);
        return (len == 0) ? 64'd1 : (len + Bpc - 1) / Bpc;
    endfunction

    // Response for the head is due `beats` cycles after it can start: the cycle after
    // both its own acceptance and the previous response handshake.
    function automatic longint headDue();
        longint start;
        start = (mq[0].acc > hPrev) ? mq[0].acc : hPrev;
        return start + 1 + mq[0].beats;
    endfunction

    // Entered and left just after a falling edge; one call is one clock cycle.
    task automatic applyStimulus(input bit vld, input logic [31:0] len, input bit ei, input bit rr);
        bit    expReady, expValid, effErr;
        rspT   expRsp;
        entryT e;
        expReady = (mq.size() < NOut);
        expValid = (mq.size() > 0) && (cyc >= headDue());
        checkOutput("ready", reqReady, expReady);
        checkOutput("rspValid", rspValid, expValid);
        checkOutput("busy", busy, mq.size() > 0);
        if (expValid) begin
            expRsp = '0;
`ifdef IDMA_REQ_RESPONDER_ERR_INJECT_EN
            expRsp.error = mq[0].err;
`endif
            checkOutput("rspPayload", rspData, expRsp);
        end
        obsValid = rspValid;
        obsBusy  = busy;
        obsReady = reqReady;
`ifdef IDMA_REQ_RESPONDER_ERR_INJECT_EN
        effErr = ei;
`else
        effErr = 1'b0;
`endif
        reqValid       = vld;
        reqData.length = len;
        errInject      = ei;
        rspReady       = rr;
        lastAccepted   = vld && expReady;
        lastPopped     = expValid && rr;
        @(posedge clk);
        if (lastPopped) begin
            popErr.push_back(mq[0].err);
            void'(mq.pop_front());
            hPrev = cyc;
        end
        if (lastAccepted) begin
            e.acc   = cyc;
            e.beats = modelBeats({32'd0, len});
            e.err   = effErr;
            mq.push_back(e);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n    = 1'b0;
        reqValid = 1'b0;
        rspReady = 1'b0;
        #1;
        checkOutput("rstReady", reqReady, 1'b1);
        checkOutput("rstValid", rspValid, 1'b0);
        checkOutput("rstRsp", rspData, 8'h00);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstCnt", dut.r_cnt, 64'd0);
        mq.delete();
        hPrev = -1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int     lat, busyCycles, idx, guard;
        longint firstPop, fifthAcc;
        logic [31:0] lens [5];

        rst_n = 1'b0; reqValid = 1'b0; rspReady = 1'b0; errInject = 1'b0; reqData = '0;
        cyc = 0; hPrev = -1;
        @(negedge clk);
        doReset();

        // Single 64-byte transfer: response 9 cycles after the handshake cycle.
        applyStimulus(1, 32'd64, 0, 1);
        lat = -1; busyCycles = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 32'd0, 0, 1);
            if (obsValid && lat < 0) lat = i;
            if (obsBusy) busyCycles++;
        end
        checkOutput("lat64", lat, 9);
        checkOutput("busy64", busyCycles, 9);

        // Zero and one byte both take one run cycle.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 32'(k), 0, 1);
            lat = -1;
            for (int i = 1; i <= 10; i++) begin
                applyStimulus(0, 32'd0, 0, 1);
                if (obsValid && lat < 0) lat = i;
            end
            checkOutput(k == 0 ? "lat0" : "lat1", lat, 2);
        end

        // Fill the queue with responses blocked, then release.
        lens[0] = 16; lens[1] = 3; lens[2] = 40; lens[3] = 0; lens[4] = 24;
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(idx < 5, lens[idx % 5], 0, 0);
            if (lastAccepted) idx++;
        end
        checkOutput("stallCount", idx, 4);
        checkOutput("stallReady", reqReady, 1'b0);
        firstPop = -1; fifthAcc = -1; guard = 0;
        while ((idx < 5 || mq.size() > 0) && guard < 200) begin
            applyStimulus(idx < 5, lens[idx % 5], 0, 1);
            if (lastPopped && firstPop < 0) firstPop = cyc - 1;
            if (lastAccepted) begin
                fifthAcc = cyc - 1;
                idx++;
            end
            guard++;
        end
        checkOutput("fifthAfterPop", fifthAcc - firstPop, 1);
        checkOutput("fullDrain", busy, 1'b0);

        // Maximum length: beat count must not wrap; then reset with work still queued.
        applyStimulus(1, 32'hFFFF_FFFF, 0, 1);
        checkOutput("hugeLoad", dut.r_cnt, 64'd536870912);
        applyStimulus(1, 32'd8, 0, 1);
        checkOutput("hugeDec", dut.r_cnt, 64'd536870911);
        applyStimulus(1, 32'd8, 0, 1);
        applyStimulus(1, 32'd8, 0, 1);
        applyStimulus(0, 32'd0, 0, 1);
        checkOutput("hugeReady", reqReady, 1'b0);
        doReset();
        for (int i = 0; i < 30; i++) applyStimulus(0, 32'd0, 0, 1);

`ifdef IDMA_REQ_RESPONDER_ERR_INJECT_EN
        popErr.delete();
        idx = 0; guard = 0;
        while ((idx < 4 || mq.size() > 0) && guard < 200) begin
            applyStimulus(idx < 4, 32'd8, (idx % 2) == 0, 1);
            if (lastAccepted) idx++;
            guard++;
        end
        checkOutput("errCount", popErr.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput("errSeq", (i < popErr.size()) ? popErr[i] : 1'bx, (i % 2) == 0);
`endif

        // Random traffic, then drain with responses always accepted.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(1, 0) == 1,
                          ($urandom_range(9, 0) == 0) ? 32'($urandom_range(200, 0))
                                                      : 32'($urandom_range(40, 0)),
                          $urandom_range(1, 0) == 1,
                          $urandom_range(3, 0) != 0);
        end
        guard = 0;
        while (mq.size() > 0 && guard < 3000) begin
            applyStimulus(0, 32'd0, 0, 1);
            guard++;
        end
        applyStimulus(0, 32'd0, 0, 1);
        checkOutput("randDrainBusy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
